// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding req/gnt/rvalid fetcher feeding a
// small instruction buffer that presents op/F/instr/pc to the decode stage
// under a valid/ready handshake. A redirect flushes the buffer and restarts
// fetch at the target; a response already in flight is discarded.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     instr,
  output logic [5:0]      op,
  output logic [2:0]      F,
  output logic [XLEN-1:0] pc_out,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DROP
  } state_t;

  state_t          state, state_nx;
  logic            started;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;

  logic [XLEN-1:0] buf_pc  [DEPTH];
  logic [31:0]     buf_ins [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic            push, pop, fire, full, full_after;
  logic            unused_lsb;

  // Target address is always word aligned; the low bits of redirect_pc are dropped.
  assign target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_lsb = ^redirect_pc[1:0];

  assign full       = (count == CW'(DEPTH));
  assign full_after = ((count + CW'(1) - CW'(pop)) == CW'(DEPTH));

  assign dec_valid  = (count != '0);
  assign pop        = dec_valid & dec_ready;
  assign instr      = buf_ins[head];
  assign pc_out     = buf_pc[head];
  assign op         = buf_ins[head][5:0];
  assign F          = buf_ins[head][14:12];
  assign imem_addr  = fetch_pc;

  // Next-state and request logic; redirect overrides the normal flow.
  // 'started' keeps imem_req low until the first edge after reset release.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    fire     = 1'b0;
    push     = 1'b0;
    case (state)
      S_REQ: begin
        if (started && !full) begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            fire     = 1'b1;
            state_nx = S_WAIT;
          end
        end else if (started) begin
          state_nx = S_FULL;
        end
        if (redirect) state_nx = fire ? S_DROP : S_REQ;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_nx = S_REQ;
          end else begin
            push     = 1'b1;
            state_nx = full_after ? S_FULL : S_REQ;
          end
        end else if (redirect) begin
          state_nx = S_DROP;
        end
      end
      S_FULL: begin
        if (redirect || pop) state_nx = S_REQ;
      end
      S_DROP: begin
        if (imem_rvalid) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  // State register and fetch address (wraps modulo 2^XLEN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      started  <= 1'b0;
      fetch_pc <= RESET_PC;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      if (redirect)  fetch_pc <= target;
      else if (fire) fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Instruction buffer: circular FIFO, flushed on redirect.
  // fetch_pc has already advanced past the outstanding word, so its pc is fetch_pc-4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_pc[i]  <= '0;
        buf_ins[i] <= '0;
      end
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        buf_pc[tail]  <= fetch_pc - XLEN'(4);
        buf_ins[tail] <= imem_rdata;
        tail          <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder, a behavioural model of the
// delivered instruction stream checked every cycle, and directed scenarios.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT u0 (RESET_PC = 0) ----------------
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        dec_valid, dec_ready;
  logic [31:0] instr, pc_out;
  logic [5:0]  op;
  logic [2:0]  F;
  logic        redirect;
  logic [31:0] redirect_pc;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .instr(instr), .op(op), .F(F), .pc_out(pc_out),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // ---------------- DUT u1 (RESET_PC = 0xFFFF_FFFC) ----------------
  logic        rst1_n;
  logic        req1, gnt1, rvalid1, valid1;
  logic [31:0] addr1, rdata1, instr1, pc1;
  logic [5:0]  unused_op1;
  logic [2:0]  unused_f1;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst1_n),
    .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1),
    .imem_rvalid(rvalid1), .imem_rdata(rdata1),
    .dec_valid(valid1), .dec_ready(1'b1),
    .instr(instr1), .op(unused_op1), .F(unused_f1), .pc_out(pc1),
    .redirect(1'b0), .redirect_pc(32'h0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory contents: address 0 holds addi x1,x0,10; elsewhere a mixing function.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return (a * 32'h0100_0101) ^ 32'h0000_5033;
  endfunction

  // ---------------- memory responder for u0 ----------------
  logic        rsp_en     = 1'b1;
  int          rv_lat     = 1;
  int          gnt_delay  = 0;
  logic        frc_gnt    = 1'b0;
  logic        frc_rvalid = 1'b0;
  logic [31:0] frc_rdata  = 32'h0;
  logic        rsp_busy   = 1'b0;
  int          rsp_left   = 0;
  logic [31:0] rsp_addr   = 32'h0;
  int          hold       = 0;
  logic        fired_gnt  = 1'b0;
  logic [31:0] fired_addr = 32'h0;

  initial begin : responder
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rsp_en) begin
        imem_gnt    = frc_gnt;
        imem_rvalid = frc_rvalid;
        imem_rdata  = frc_rdata;
        rsp_busy    = 1'b0;
        hold        = 0;
      end else begin
        imem_rvalid = 1'b0;
        if (fired_gnt) begin
          rsp_busy = 1'b1;
          rsp_left = rv_lat;
          rsp_addr = fired_addr;
        end
        if (rsp_busy) begin
          rsp_left--;
          if (rsp_left <= 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rsp_addr);
            rsp_busy    = 1'b0;
          end
        end
        if (imem_req) begin
          imem_gnt = (hold >= gnt_delay);
          hold     = imem_gnt ? 0 : hold + 1;
        end else begin
          imem_gnt = 1'b0;
          hold     = 0;
        end
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare (u0) ----------------
  logic [31:0] exp_pc = 32'h0, exp_fetch = 32'h0;
  logic [31:0] gnt_q[$];
  logic [31:0] hs_q[$];
  logic        prev_redirect = 1'b0, prev_req_hold = 1'b0, prev_head_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_pc = 32'h0, prev_instr = 32'h0;

  always @(negedge clk) begin : compare
    if (!rst_n) begin
      chk("rst_req",   32'(imem_req), 32'h0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", 32'(dec_valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc",    pc_out, 32'h0);
      chk("rst_opf",   32'({op, F}), 32'h0);
      exp_pc = 32'h0; exp_fetch = 32'h0;
      gnt_q.delete(); hs_q.delete();
      fired_gnt = 1'b0;
      prev_redirect = 1'b0; prev_req_hold = 1'b0; prev_head_hold = 1'b0;
    end else begin
      if (prev_redirect) chk("flush_valid", 32'(dec_valid), 32'h0);
      if (prev_req_hold) begin
        chk("req_hold",  32'(imem_req), 32'h1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (prev_head_hold) begin
        chk("head_valid", 32'(dec_valid), 32'h1);
        chk("head_pc",    pc_out, prev_pc);
        chk("head_instr", instr, prev_instr);
      end
      if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
      if (dec_valid) chk("op_f_fields", 32'({op, F}), 32'({instr[5:0], instr[14:12]}));
      if (dec_valid && dec_ready) begin
        chk("deliv_pc",    pc_out, exp_pc);
        chk("deliv_instr", instr, mem_word(exp_pc));
        hs_q.push_back(pc_out);
        exp_pc = exp_pc + 32'd4;
      end
      fired_gnt  = imem_req && imem_gnt;
      fired_addr = imem_addr;
      if (fired_gnt) begin
        chk("one_outstanding", 32'(rsp_busy || imem_rvalid), 32'h0);
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        gnt_q.push_back(imem_addr);
      end
      if (redirect) begin
        exp_pc    = {redirect_pc[31:2], 2'b00};
        exp_fetch = {redirect_pc[31:2], 2'b00};
        gnt_q.delete();
        hs_q.delete();
      end
      prev_redirect  = redirect;
      prev_req_hold  = imem_req && !imem_gnt && !redirect;
      prev_addr      = imem_addr;
      prev_head_hold = dec_valid && !dec_ready && !redirect;
      prev_pc        = pc_out;
      prev_instr     = instr;
    end
  end

  // ---------------- u1 responder and capture ----------------
  logic        fired1 = 1'b0;
  logic [31:0] fired1_addr = 32'h0;
  logic [31:0] q_gnt1[$];
  logic [31:0] q_pc1[$];
  logic [31:0] q_ins1[$];

  initial begin : responder1
    gnt1 = 1'b0; rvalid1 = 1'b0; rdata1 = 32'h0;
    forever begin
      @(posedge clk); #1;
      rvalid1 = fired1;
      rdata1  = mem_word(fired1_addr);
      gnt1    = req1;
    end
  end

  always @(negedge clk) begin : capture1
    if (rst1_n) begin
      fired1      = req1 && gnt1;
      fired1_addr = addr1;
      if (fired1) q_gnt1.push_back(addr1);
      if (valid1) begin
        q_pc1.push_back(pc1);
        q_ins1.push_back(instr1);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    tick();
    redirect    = 1'b0;
    redirect_pc = 32'h0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b0; rst1_n = 1'b0;
    dec_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();

    // 1: reset release, first fetch and delivery
    rst_n = 1'b1; rst1_n = 1'b1;
    #1 chk("t1_req_low_before_edge", 32'(imem_req), 32'h0);
    tick();
    chk("t1_req_up", 32'(imem_req), 32'h1);
    chk("t1_addr0",  imem_addr, 32'h0);
    tick();
    chk("t1_not_valid_yet", 32'(dec_valid), 32'h0);
    tick();
    chk("t1_valid",  32'(dec_valid), 32'h1);
    chk("t1_instr",  instr, 32'h00A0_0093);
    chk("t1_op",     32'(op), 32'h13);
    chk("t1_F",      32'(F), 32'h0);
    chk("t1_pc",     pc_out, 32'h0);
    chk("t1_next_addr", imem_addr, 32'h4);
    repeat (8) tick();

    // 2: decode stalled -> exactly two words buffered, then drain and resume
    dec_ready = 1'b0;
    pulse_redirect(32'h40);
    repeat (12) tick();
    chk("t2_grants",   32'(gnt_q.size()), 32'd2);
    chk("t2_req_low",  32'(imem_req), 32'h0);
    chk("t2_valid",    32'(dec_valid), 32'h1);
    chk("t2_head_pc",  pc_out, 32'h40);
    dec_ready = 1'b1;
    for (int i = 0; i < 30 && !(gnt_q.size() >= 3 && hs_q.size() >= 2); i++) tick();
    chk("t2_drain_done", 32'(gnt_q.size() >= 3 && hs_q.size() >= 2), 32'h1);
    if (gnt_q.size() >= 3 && hs_q.size() >= 2) begin
      chk("t2_pop0",   hs_q[0], 32'h40);
      chk("t2_pop1",   hs_q[1], 32'h44);
      chk("t2_resume", gnt_q[2], 32'h48);
    end

    // 3: redirect while waiting for data
    rv_lat = 3;
    for (int i = 0; i < 20 && !(rsp_busy && !imem_rvalid); i++) tick();
    chk("t3_in_wait", 32'(rsp_busy && !imem_rvalid), 32'h1);
    pulse_redirect(32'h103);
    chk("t3_flush", 32'(dec_valid), 32'h0);
    for (int i = 0; i < 40 && hs_q.size() < 1; i++) tick();
    chk("t3_delivered", 32'(hs_q.size() >= 1), 32'h1);
    if (hs_q.size() >= 1) begin
      chk("t3_first_addr", gnt_q[0], 32'h100);
      chk("t3_first_pc",   hs_q[0], 32'h100);
    end
    rv_lat = 1;

    // 4a: redirect in the same cycle as rvalid
    for (int i = 0; i < 20 && !imem_rvalid; i++) tick();
    chk("t4a_rvalid_seen", 32'(imem_rvalid), 32'h1);
    pulse_redirect(32'h300);
    chk("t4a_flush", 32'(dec_valid), 32'h0);
    for (int i = 0; i < 40 && hs_q.size() < 1; i++) tick();
    chk("t4a_delivered", 32'(hs_q.size() >= 1), 32'h1);
    if (hs_q.size() >= 1) begin
      chk("t4a_first_addr", gnt_q[0], 32'h300);
      chk("t4a_first_pc",   hs_q[0], 32'h300);
    end

    // 4b: redirect in the same cycle as gnt
    for (int i = 0; i < 20 && !(imem_req && imem_gnt); i++) tick();
    chk("t4b_gnt_seen", 32'(imem_req && imem_gnt), 32'h1);
    pulse_redirect(32'h500);
    chk("t4b_flush", 32'(dec_valid), 32'h0);
    for (int i = 0; i < 40 && hs_q.size() < 1; i++) tick();
    chk("t4b_delivered", 32'(hs_q.size() >= 1), 32'h1);
    if (hs_q.size() >= 1) begin
      chk("t4b_first_addr", gnt_q[0], 32'h500);
      chk("t4b_first_pc",   hs_q[0], 32'h500);
    end

    // 4c: redirect while a request is pending without gnt -> withdrawn, new addr next cycle
    gnt_delay = 3;
    for (int i = 0; i < 20 && !(imem_req && !imem_gnt); i++) tick();
    chk("t4c_pending", 32'(imem_req && !imem_gnt), 32'h1);
    pulse_redirect(32'h600);
    chk("t4c_req",  32'(imem_req), 32'h1);
    chk("t4c_addr", imem_addr, 32'h600);
    gnt_delay = 0;
    for (int i = 0; i < 40 && hs_q.size() < 1; i++) tick();
    chk("t4c_delivered", 32'(hs_q.size() >= 1), 32'h1);
    if (hs_q.size() >= 1) chk("t4c_first_pc", hs_q[0], 32'h600);

    // 6: reset while waiting for data; stray rvalid during and after reset
    rv_lat = 3;
    for (int i = 0; i < 20 && !(rsp_busy && !imem_rvalid); i++) tick();
    chk("t6_in_wait", 32'(rsp_busy && !imem_rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   32'(imem_req), 32'h0);
    chk("t6_rst_valid", 32'(dec_valid), 32'h0);
    chk("t6_rst_instr", instr, 32'h0);
    rsp_en = 1'b0; frc_gnt = 1'b0; frc_rvalid = 1'b1; frc_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_stray_ignored", 32'(dec_valid), 32'h0);
    frc_rvalid = 1'b0;
    rv_lat = 1;
    rsp_en = 1'b1;
    tick();
    chk("t6_still_empty", 32'(dec_valid), 32'h0);
    for (int i = 0; i < 40 && hs_q.size() < 1; i++) tick();
    chk("t6_delivered", 32'(hs_q.size() >= 1), 32'h1);
    if (hs_q.size() >= 1) begin
      chk("t6_refetch_addr", gnt_q[0], 32'h0);
      chk("t6_refetch_pc",   hs_q[0], 32'h0);
    end
    repeat (6) tick();

    // 5: RESET_PC at top of address space wraps to zero
    chk("t5_count", 32'(q_gnt1.size() >= 3 && q_pc1.size() >= 3), 32'h1);
    if (q_gnt1.size() >= 3 && q_pc1.size() >= 3) begin
      chk("t5_addr0", q_gnt1[0], 32'hFFFF_FFFC);
      chk("t5_addr1", q_gnt1[1], 32'h0000_0000);
      chk("t5_addr2", q_gnt1[2], 32'h0000_0004);
      chk("t5_pc0",   q_pc1[0],  32'hFFFF_FFFC);
      chk("t5_pc1",   q_pc1[1],  32'h0000_0000);
      chk("t5_ins1",  q_ins1[1], 32'h00A0_0093);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
